scr1_dmem_copier: RTL and testbench
===================================

Name: scr1_dmem_copier

Overview:
- Word-granular copy engine; acts as an initiator on the SCR1 dmem request/response interface.
- Sits beside the core as a second dmem master in front of the dmem router. Drives memory-mapped responders such as the timer and TCM.
- Software-visible control arrives from a small CSR shim as start/src/dst/len strobes. The block reports busy, done, error and progress.

Parameters:
- LEN_WIDTH, 16, width of the word-count and progress counters.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle start strobe; honoured only while idle
- src_addr  in  `SCR1_DMEM_AWIDTH  source byte address; must be word aligned
- dst_addr  in  `SCR1_DMEM_AWIDTH  destination byte address; must be word aligned
- len_words  in  LEN_WIDTH  number of 32-bit words to copy
- abort  in  1  level; stops the transfer at the next word boundary
- fill  in  1  fill mode select (see Optional Feature)
- fill_data  in  `SCR1_DMEM_DWIDTH  fill pattern
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse on completion, abort or error
- error  out  1  sticky error flag; cleared by an accepted start
- words_done  out  LEN_WIDTH  count of words written successfully
- dmem_req  out  1  request valid
- dmem_cmd  out  type_scr1_mem_cmd_e  SCR1_MEM_CMD_RD or SCR1_MEM_CMD_WR
- dmem_width  out  type_scr1_mem_width_e  always SCR1_MEM_WIDTH_WORD
- dmem_addr  out  `SCR1_DMEM_AWIDTH  request address
- dmem_wdata  out  `SCR1_DMEM_DWIDTH  write data
- dmem_req_ack  in  1  responder accepted the request this cycle
- dmem_rdata  in  `SCR1_DMEM_DWIDTH  read data, valid with the response
- dmem_resp  in  type_scr1_mem_resp_e  NOTRDY / RDY_OK / RDY_ER

Behaviour:
- Reset values:
  - outputs: busy=0, done=0, error=0, words_done=0, dmem_req=0, dmem_cmd=RD, dmem_addr=0, dmem_wdata=0.
  - internal state: FSM=IDLE.
- FSM states: IDLE, RD_REQ, RD_RESP, WR_REQ, WR_RESP, FIN.
- IDLE + start:
  - Latch src, dst, len and fill. Clear error and words_done. busy=1.
  - If src[1:0] or dst[1:0] is nonzero: error=1, go to FIN with no bus activity.
  - Else if len==0: go to FIN with no bus activity.
  - Else go to RD_REQ, or to WR_REQ when fill mode is active.
- RD_REQ / WR_REQ:
  - dmem_req=1. cmd, addr and wdata are driven from registers and held stable until the request is accepted.
  - Accepted means dmem_req & dmem_req_ack at a rising clk edge. On acceptance go to the matching *_RESP state and drop dmem_req.
- RD_RESP / WR_RESP:
  - dmem_resp is sampled only in cycles after acceptance. Wait while it is NOTRDY; there is no timeout.
  - RDY_ER: set error, go to FIN.
  - RDY_OK in RD_RESP: capture dmem_rdata into the data register, go to WR_REQ.
  - RDY_OK in WR_RESP:
    - words_done+1; src and dst each +4, wrapping modulo 2^AWIDTH; remaining-1.
    - Go to FIN if remaining reaches 0 or abort is high.
    - Otherwise go to RD_REQ, or WR_REQ in fill mode.
- FIN: done=1 for exactly one cycle, busy=0, return to IDLE.
- At most one transaction is outstanding. There is no request in the same cycle as a response.
- abort is never applied mid-transaction: an accepted request always waits for its response. Abort while idle is ignored.
- start while busy is ignored.
- Minimum per word with a zero-wait responder (ack same cycle, resp next cycle): 4 cycles copy, 2 cycles fill.
- words_done saturates naturally because len is capped at 2^LEN_WIDTH-1.

Optional Feature:
- Macro SCR1_DMA_FILL_EN.
- Defined: fill sampled at start. When fill is set, read states are skipped and fill_data is written to dst..dst+4*(len-1).
- Undefined: the fill and fill_data ports remain but are ignored. Every transfer is a copy, and RD states are always visited.

Decomposition:
- Package scr1_dma_pkg holds:
  - typedef type_scr1_dma_fsm_e (the six states);
  - localparam SCR1_DMA_WORD_BYTES=4.
- Memory command, width and response enums come from scr1_memif.h, unchanged.
- No sub-module: the FSM, address counters and data register are a single module.

Test Plan:
- Copy: src=0x100, dst=0x200, len=3, zero-wait responder preloaded 0xA,0xB,0xC → three RD then three WR at 0x200/0x204/0x208 with 0xA,0xB,0xC; words_done=3; done pulse at cycle 13 after start; error=0.
- Backpressure: dmem_req_ack low for 5 cycles on the first WR, then NOTRDY for 3 cycles → addr/wdata stable throughout; exactly one write issued; result identical to the zero-wait case.
- Error: second read returns RDY_ER → error=1, words_done=1, done pulse, no further requests. Next start clears error.
- Boundaries:
  - len=0 → done after 2 cycles, no dmem_req.
  - src=0x102 → error=1, no dmem_req.
  - dst=0xFFFF_FFFC with len=2 → second write targets 0x0000_0000.
- Abort: raise abort during the read of word 2 of len=8 → word 2 completes both read and write, words_done=2, done pulse, error=0. A start while busy is ignored.
- Fill (SCR1_DMA_FILL_EN defined): fill=1, fill_data=0xDEADBEEF, dst=0x300, len=4 → four writes only, no RD. With the macro undefined, the same stimulus performs a copy.

Source files
------------

// File: rtl/scr1_dma_pkg.sv
// Shared types for the dmem copy engine.
// The memory command/width/response enums and the dmem bus width macros
// reproduce the SCR1 scr1_memif.h / architecture definitions verbatim, so the
// copier can connect directly to the dmem router.

`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

package scr1_dma_pkg;

  // dmem request command
  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  // dmem access width
  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
  } type_scr1_mem_width_e;

  // dmem response status
  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  // Copy engine control states
  typedef enum logic [2:0] {
    SCR1_DMA_IDLE    = 3'd0,
    SCR1_DMA_RD_REQ  = 3'd1,
    SCR1_DMA_RD_RESP = 3'd2,
    SCR1_DMA_WR_REQ  = 3'd3,
    SCR1_DMA_WR_RESP = 3'd4,
    SCR1_DMA_FIN     = 3'd5
  } type_scr1_dma_fsm_e;

  localparam int unsigned SCR1_DMA_WORD_BYTES = 4;

  // A transfer is only legal when both byte addresses sit on a word boundary.
  function automatic logic dma_misaligned(input logic [1:0] src_lo,
                                          input logic [1:0] dst_lo);
    return |{src_lo, dst_lo};
  endfunction

endpackage

// File: rtl/scr1_dmem_copier.sv
// Word-granular dmem copy/fill engine acting as a second dmem initiator.
// One transaction outstanding at a time: request, wait for response, next.
// Optional feature macro: SCR1_DMA_FILL_EN -- when defined, a transfer started
// with fill=1 skips the reads and writes fill_data to every destination word.
// When undefined, fill and fill_data are ignored and every transfer copies.

module scr1_dmem_copier
  import scr1_dma_pkg::*;
#(
  parameter int LEN_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [`SCR1_DMEM_AWIDTH-1:0]   src_addr,
  input  logic [`SCR1_DMEM_AWIDTH-1:0]   dst_addr,
  input  logic [LEN_WIDTH-1:0]           len_words,
  input  logic                           abort,
  input  logic                           fill,
  input  logic [`SCR1_DMEM_DWIDTH-1:0]   fill_data,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
  output logic [LEN_WIDTH-1:0]           words_done,
  output logic                           dmem_req,
  output type_scr1_mem_cmd_e             dmem_cmd,
  output type_scr1_mem_width_e           dmem_width,
  output logic [`SCR1_DMEM_AWIDTH-1:0]   dmem_addr,
  output logic [`SCR1_DMEM_DWIDTH-1:0]   dmem_wdata,
  input  logic                           dmem_req_ack,
  input  logic [`SCR1_DMEM_DWIDTH-1:0]   dmem_rdata,
  input  type_scr1_mem_resp_e            dmem_resp
);

  localparam int AW = `SCR1_DMEM_AWIDTH;
  localparam int DW = `SCR1_DMEM_DWIDTH;
  localparam logic [AW-1:0]        ADDR_STEP = AW'(SCR1_DMA_WORD_BYTES);
  localparam logic [LEN_WIDTH-1:0] LEN_ZERO  = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0] LEN_ONE   = LEN_WIDTH'(1);

  // Registered state
  type_scr1_dma_fsm_e    r_state;
  logic [AW-1:0]         r_src;
  logic [AW-1:0]         r_dst;
  logic [LEN_WIDTH-1:0]  r_rem;
  logic [DW-1:0]         r_data;
  logic                  r_fill;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;
  logic [LEN_WIDTH-1:0]  r_words_done;
  logic                  r_req;
  type_scr1_mem_cmd_e    r_cmd;
  logic [AW-1:0]         r_addr;
  logic [DW-1:0]         r_wdata;

  // Next-state values
  type_scr1_dma_fsm_e    w_state_nxt;
  logic [AW-1:0]         w_src_nxt;
  logic [AW-1:0]         w_dst_nxt;
  logic [LEN_WIDTH-1:0]  w_rem_nxt;
  logic [DW-1:0]         w_data_nxt;
  logic                  w_fill_nxt;
  logic                  w_busy_nxt;
  logic                  w_done_nxt;
  logic                  w_error_nxt;
  logic [LEN_WIDTH-1:0]  w_words_nxt;
  logic                  w_req_nxt;
  type_scr1_mem_cmd_e    w_cmd_nxt;
  logic [AW-1:0]         w_addr_nxt;
  logic [DW-1:0]         w_wdata_nxt;

  // Fill-mode selection and the value preloaded into the data register at start
  logic                  w_fill_start;
  logic [DW-1:0]         w_fill_pattern;
  logic                  w_req_accepted;

`ifdef SCR1_DMA_FILL_EN
  assign w_fill_start   = fill;
  assign w_fill_pattern = fill_data;
`else
  // Fill ports are kept for a stable interface but have no effect.
  logic w_unused_fill;
  assign w_unused_fill  = ^{fill, fill_data};
  assign w_fill_start   = 1'b0;
  assign w_fill_pattern = {DW{1'b0}};
`endif

  assign w_req_accepted = r_req & dmem_req_ack;

  // Control FSM next state, counters and next values of the bus registers
  always_comb begin
    w_state_nxt = r_state;
    w_src_nxt   = r_src;
    w_dst_nxt   = r_dst;
    w_rem_nxt   = r_rem;
    w_data_nxt  = r_data;
    w_fill_nxt  = r_fill;
    w_error_nxt = r_error;
    w_words_nxt = r_words_done;

    case (r_state)
      SCR1_DMA_IDLE: begin
        if (start) begin
          w_src_nxt   = src_addr;
          w_dst_nxt   = dst_addr;
          w_rem_nxt   = len_words;
          w_fill_nxt  = w_fill_start;
          w_words_nxt = LEN_ZERO;
          // In fill mode no read ever overwrites the data register.
          w_data_nxt  = w_fill_start ? w_fill_pattern : r_data;
          if (dma_misaligned(src_addr[1:0], dst_addr[1:0])) begin
            w_error_nxt = 1'b1;
            w_state_nxt = SCR1_DMA_FIN;
          end else if (len_words == LEN_ZERO) begin
            w_error_nxt = 1'b0;
            w_state_nxt = SCR1_DMA_FIN;
          end else if (w_fill_start) begin
            w_error_nxt = 1'b0;
            w_state_nxt = SCR1_DMA_WR_REQ;
          end else begin
            w_error_nxt = 1'b0;
            w_state_nxt = SCR1_DMA_RD_REQ;
          end
        end else begin
          w_state_nxt = SCR1_DMA_IDLE;
        end
      end

      SCR1_DMA_RD_REQ: begin
        if (w_req_accepted) begin
          w_state_nxt = SCR1_DMA_RD_RESP;
        end else begin
          w_state_nxt = SCR1_DMA_RD_REQ;
        end
      end

      SCR1_DMA_RD_RESP: begin
        case (dmem_resp)
          SCR1_MEM_RESP_RDY_OK: begin
            w_data_nxt  = dmem_rdata;
            w_state_nxt = SCR1_DMA_WR_REQ;
          end
          SCR1_MEM_RESP_RDY_ER: begin
            w_error_nxt = 1'b1;
            w_state_nxt = SCR1_DMA_FIN;
          end
          default: begin
            w_state_nxt = SCR1_DMA_RD_RESP;
          end
        endcase
      end

      SCR1_DMA_WR_REQ: begin
        if (w_req_accepted) begin
          w_state_nxt = SCR1_DMA_WR_RESP;
        end else begin
          w_state_nxt = SCR1_DMA_WR_REQ;
        end
      end

      SCR1_DMA_WR_RESP: begin
        case (dmem_resp)
          SCR1_MEM_RESP_RDY_OK: begin
            w_words_nxt = r_words_done + LEN_ONE;
            w_src_nxt   = r_src + ADDR_STEP;
            w_dst_nxt   = r_dst + ADDR_STEP;
            w_rem_nxt   = r_rem - LEN_ONE;
            // abort is honoured only here, at a completed word boundary
            if ((r_rem == LEN_ONE) || abort) begin
              w_state_nxt = SCR1_DMA_FIN;
            end else if (r_fill) begin
              w_state_nxt = SCR1_DMA_WR_REQ;
            end else begin
              w_state_nxt = SCR1_DMA_RD_REQ;
            end
          end
          SCR1_MEM_RESP_RDY_ER: begin
            w_error_nxt = 1'b1;
            w_state_nxt = SCR1_DMA_FIN;
          end
          default: begin
            w_state_nxt = SCR1_DMA_WR_RESP;
          end
        endcase
      end

      SCR1_DMA_FIN: begin
        w_state_nxt = SCR1_DMA_IDLE;
      end

      default: begin
        w_state_nxt = SCR1_DMA_IDLE;
      end
    endcase

    // Bus registers are loaded on entry to a request state and then held
    // untouched until that request is accepted.
    w_req_nxt   = 1'b0;
    w_cmd_nxt   = r_cmd;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    case (w_state_nxt)
      SCR1_DMA_RD_REQ: begin
        w_req_nxt  = 1'b1;
        w_cmd_nxt  = SCR1_MEM_CMD_RD;
        w_addr_nxt = w_src_nxt;
      end
      SCR1_DMA_WR_REQ: begin
        w_req_nxt   = 1'b1;
        w_cmd_nxt   = SCR1_MEM_CMD_WR;
        w_addr_nxt  = w_dst_nxt;
        w_wdata_nxt = w_data_nxt;
      end
      default: begin
        w_req_nxt = 1'b0;
      end
    endcase

    w_busy_nxt = (w_state_nxt == SCR1_DMA_RD_REQ)  || (w_state_nxt == SCR1_DMA_RD_RESP) ||
                 (w_state_nxt == SCR1_DMA_WR_REQ)  || (w_state_nxt == SCR1_DMA_WR_RESP);
    w_done_nxt = (w_state_nxt == SCR1_DMA_FIN);
  end

  // State, counters, data register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= SCR1_DMA_IDLE;
      r_src        <= {AW{1'b0}};
      r_dst        <= {AW{1'b0}};
      r_rem        <= LEN_ZERO;
      r_data       <= {DW{1'b0}};
      r_fill       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_words_done <= LEN_ZERO;
      r_req        <= 1'b0;
      r_cmd        <= SCR1_MEM_CMD_RD;
      r_addr       <= {AW{1'b0}};
      r_wdata      <= {DW{1'b0}};
    end else begin
      r_state      <= w_state_nxt;
      r_src        <= w_src_nxt;
      r_dst        <= w_dst_nxt;
      r_rem        <= w_rem_nxt;
      r_data       <= w_data_nxt;
      r_fill       <= w_fill_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_error      <= w_error_nxt;
      r_words_done <= w_words_nxt;
      r_req        <= w_req_nxt;
      r_cmd        <= w_cmd_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign words_done = r_words_done;
  assign dmem_req   = r_req;
  assign dmem_cmd   = r_cmd;
  assign dmem_width = SCR1_MEM_WIDTH_WORD;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;

endmodule

// File: tb/tb_scr1_dmem_copier.sv
// Directed bench for scr1_dmem_copier with a behavioural dmem responder
// (configurable ack stall / NOTRDY delay on the first write, read error inject).

module tb_scr1_dmem_copier;
  import scr1_dma_pkg::*;

  localparam int LW = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic [31:0]          src_addr, dst_addr;
  logic [LW-1:0]        len_words;
  logic                 abort, fill;
  logic [31:0]          fill_data;
  logic                 busy, done, error;
  logic [LW-1:0]        words_done;
  logic                 dmem_req;
  type_scr1_mem_cmd_e   dmem_cmd;
  type_scr1_mem_width_e dmem_width;
  logic [31:0]          dmem_addr, dmem_wdata;
  logic                 dmem_req_ack;
  logic [31:0]          dmem_rdata;
  type_scr1_mem_resp_e  dmem_resp;

  always #5 clk = ~clk;

  scr1_dmem_copier #(.LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len_words(len_words), .abort(abort), .fill(fill), .fill_data(fill_data),
    .busy(busy), .done(done), .error(error), .words_done(words_done),
    .dmem_req(dmem_req), .dmem_cmd(dmem_cmd), .dmem_width(dmem_width),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_req_ack(dmem_req_ack),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Responder state and transaction logs
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_addr_q[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int  rd_cnt = 0, wr_cnt = 0;
  int  ack_stall_cfg = 0, notrdy_cfg = 0, err_rd_idx = -1;
  int  stall_cnt = 0, wait_cnt = 0, proto_errs = 0;
  bit  pending = 0, ack_given = 0, resp_out = 0, wr_seen = 0, prev_req = 0;
  type_scr1_mem_cmd_e pend_cmd = SCR1_MEM_CMD_RD, prev_cmd = SCR1_MEM_CMD_RD;
  logic [31:0] pend_addr = 32'h0, pend_wdata = 32'h0, prev_addr = 32'h0, prev_wdata = 32'h0;

  // Responder: decides ack/resp on the falling edge for the next rising edge
  always @(negedge clk) begin
    if (!rst_n) begin
      dmem_req_ack = 1'b0;
      dmem_resp    = SCR1_MEM_RESP_NOTRDY;
      pending = 0; ack_given = 0; resp_out = 0; prev_req = 0;
    end else begin
      if (resp_out) begin
        dmem_resp = SCR1_MEM_RESP_NOTRDY;
        resp_out  = 0;
      end
      if (ack_given) begin
        ack_given = 0;
        pending   = 1;
      end
      if (pending && dmem_req) proto_errs++;
      if (dmem_req && prev_req &&
          (dmem_addr !== prev_addr || dmem_wdata !== prev_wdata || dmem_cmd !== prev_cmd))
        proto_errs++;
      if (dmem_req && dmem_cmd == SCR1_MEM_CMD_WR && !wr_seen) begin
        wr_seen   = 1;
        stall_cnt = ack_stall_cfg;
      end
      dmem_req_ack = 1'b0;
      if (pending) begin
        if (wait_cnt > 0) begin
          wait_cnt--;
        end else begin
          pending  = 0;
          resp_out = 1;
          if (pend_cmd == SCR1_MEM_CMD_RD) begin
            if (rd_cnt - 1 == err_rd_idx) begin
              dmem_resp = SCR1_MEM_RESP_RDY_ER;
            end else begin
              dmem_rdata = mem.exists(pend_addr) ? mem[pend_addr] : 32'h0;
              dmem_resp  = SCR1_MEM_RESP_RDY_OK;
            end
          end else begin
            mem[pend_addr] = pend_wdata;
            dmem_resp      = SCR1_MEM_RESP_RDY_OK;
          end
        end
      end else if (dmem_req) begin
        if (stall_cnt > 0) begin
          stall_cnt--;
        end else begin
          dmem_req_ack = 1'b1;
          ack_given    = 1;
          pend_cmd     = dmem_cmd;
          pend_addr    = dmem_addr;
          pend_wdata   = dmem_wdata;
          if (dmem_cmd == SCR1_MEM_CMD_RD) begin
            rd_addr_q.push_back(dmem_addr);
            rd_cnt++;
            wait_cnt = 0;
          end else begin
            wr_addr_q.push_back(dmem_addr);
            wr_data_q.push_back(dmem_wdata);
            wr_cnt++;
            wait_cnt = (wr_cnt == 1) ? notrdy_cfg : 0;
          end
        end
      end
      prev_req   = dmem_req && !dmem_req_ack;
      prev_cmd   = dmem_cmd;
      prev_addr  = dmem_addr;
      prev_wdata = dmem_wdata;
    end
  end

  function automatic logic [31:0] wa(input int i);
    return (i < wr_addr_q.size()) ? wr_addr_q[i] : 32'hxxxx_xxxx;
  endfunction
  function automatic logic [31:0] wd(input int i);
    return (i < wr_data_q.size()) ? wr_data_q[i] : 32'hxxxx_xxxx;
  endfunction
  function automatic logic [31:0] ra(input int i);
    return (i < rd_addr_q.size()) ? rd_addr_q[i] : 32'hxxxx_xxxx;
  endfunction

  // Start one transfer and wait (bounded) for done; lat = rising edges from
  // the edge that samples start up to and including the one raising done.
  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input logic [LW-1:0] n,
                          input logic f, input logic [31:0] fd, input int abort_at_rd,
                          output int lat);
    bit seen;
    rd_addr_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    rd_cnt = 0; wr_cnt = 0; wr_seen = 0; proto_errs = 0;
    @(negedge clk);
    src_addr = s; dst_addr = d; len_words = n; fill = f; fill_data = fd; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 0;
    lat  = 0;
    for (int c = 1; c <= 300 && !seen; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        lat  = c;
      end else if (abort_at_rd > 0 && rd_cnt >= abort_at_rd && !abort) begin
        abort = 1'b1;
        // a start with other parameters while busy must be ignored
        start = 1'b1; src_addr = 32'h800; dst_addr = 32'h900; len_words = 16'd1;
      end else begin
        start = 1'b0;
      end
    end
    abort = 1'b0;
    start = 1'b0;
    check_eq("done_timeout", {31'd0, seen}, 32'd1);
  endtask

  int lat;
  int grants;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; fill = 1'b0;
    src_addr = 32'h0; dst_addr = 32'h0; len_words = 16'd0; fill_data = 32'h0;
    dmem_req_ack = 1'b0; dmem_rdata = 32'h0; dmem_resp = SCR1_MEM_RESP_NOTRDY;
    mem[32'h100] = 32'hA; mem[32'h104] = 32'hB; mem[32'h108] = 32'hC;
    mem[32'h500] = 32'h1111_1111; mem[32'h504] = 32'h2222_2222;
    for (int i = 0; i < 8; i++) mem[32'h700 + 32'(4 * i)] = 32'h70 + 32'(i);
    for (int i = 0; i < 4; i++) mem[32'h400 + 32'(4 * i)] = 32'h40 + 32'(i);

    repeat (3) @(negedge clk);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_error", {31'd0, error}, 32'd0);
    check_eq("rst_words", {16'd0, words_done}, 32'd0);
    check_eq("rst_req", {31'd0, dmem_req}, 32'd0);
    check_eq("rst_cmd", {31'd0, dmem_cmd}, 32'd0);
    check_eq("rst_addr", dmem_addr, 32'h0);
    check_eq("rst_wdata", dmem_wdata, 32'h0);
    rst_n = 1'b1;

    // Plain copy with a zero-wait responder
    run_xfer(32'h100, 32'h200, 16'd3, 1'b0, 32'h0, 0, lat);
    check_eq("copy_latency", lat, 32'd13);
    check_eq("copy_words", {16'd0, words_done}, 32'd3);
    check_eq("copy_error", {31'd0, error}, 32'd0);
    check_eq("copy_busy_fin", {31'd0, busy}, 32'd0);
    check_eq("copy_width", {30'd0, dmem_width}, 32'd2);
    check_eq("copy_rd_cnt", rd_cnt, 32'd3);
    check_eq("copy_wr_cnt", wr_cnt, 32'd3);
    for (int i = 0; i < 3; i++) begin
      check_eq("copy_rd_addr", ra(i), 32'h100 + 32'(4 * i));
      check_eq("copy_wr_addr", wa(i), 32'h200 + 32'(4 * i));
      check_eq("copy_wr_data", wd(i), 32'hA + 32'(i));
    end
    @(negedge clk);
    check_eq("done_one_cycle", {31'd0, done}, 32'd0);

    // Backpressure on the first write: 5 cycles without ack, then 3 NOTRDY
    ack_stall_cfg = 5; notrdy_cfg = 3;
    run_xfer(32'h100, 32'h200, 16'd3, 1'b0, 32'h0, 0, lat);
    ack_stall_cfg = 0; notrdy_cfg = 0;
    check_eq("bp_stable", proto_errs, 32'd0);
    check_eq("bp_wr_cnt", wr_cnt, 32'd3);
    check_eq("bp_words", {16'd0, words_done}, 32'd3);
    check_eq("bp_error", {31'd0, error}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_wr_addr", wa(i), 32'h200 + 32'(4 * i));
      check_eq("bp_wr_data", wd(i), 32'hA + 32'(i));
    end

    // Error response on the second read
    err_rd_idx = 1;
    run_xfer(32'h100, 32'h200, 16'd3, 1'b0, 32'h0, 0, lat);
    err_rd_idx = -1;
    check_eq("err_flag", {31'd0, error}, 32'd1);
    check_eq("err_words", {16'd0, words_done}, 32'd1);
    check_eq("err_rd_cnt", rd_cnt, 32'd2);
    check_eq("err_wr_cnt", wr_cnt, 32'd1);
    grants = rd_cnt + wr_cnt;
    repeat (4) @(negedge clk);
    check_eq("err_no_more_req", rd_cnt + wr_cnt, grants);
    check_eq("err_sticky", {31'd0, error}, 32'd1);
    run_xfer(32'h100, 32'h200, 16'd1, 1'b0, 32'h0, 0, lat);
    check_eq("err_cleared", {31'd0, error}, 32'd0);
    check_eq("err_next_words", {16'd0, words_done}, 32'd1);

    // Zero length: no bus activity
    run_xfer(32'h100, 32'h200, 16'd0, 1'b0, 32'h0, 0, lat);
    check_eq("len0_fast", {31'd0, (lat >= 1 && lat <= 2)}, 32'd1);
    check_eq("len0_no_req", rd_cnt + wr_cnt, 32'd0);
    check_eq("len0_error", {31'd0, error}, 32'd0);
    check_eq("len0_words", {16'd0, words_done}, 32'd0);

    // Misaligned source / destination
    run_xfer(32'h102, 32'h200, 16'd2, 1'b0, 32'h0, 0, lat);
    check_eq("msrc_error", {31'd0, error}, 32'd1);
    check_eq("msrc_no_req", rd_cnt + wr_cnt, 32'd0);
    run_xfer(32'h100, 32'h201, 16'd2, 1'b0, 32'h0, 0, lat);
    check_eq("mdst_error", {31'd0, error}, 32'd1);
    check_eq("mdst_no_req", rd_cnt + wr_cnt, 32'd0);

    // Destination wraps past the top of the address space
    run_xfer(32'h500, 32'hFFFF_FFFC, 16'd2, 1'b0, 32'h0, 0, lat);
    check_eq("wrap_wr0_addr", wa(0), 32'hFFFF_FFFC);
    check_eq("wrap_wr1_addr", wa(1), 32'h0000_0000);
    check_eq("wrap_wr1_data", wd(1), 32'h2222_2222);
    check_eq("wrap_words", {16'd0, words_done}, 32'd2);

    // Abort raised while word 2 is being read; a start while busy is ignored
    run_xfer(32'h700, 32'hA00, 16'd8, 1'b0, 32'h0, 2, lat);
    check_eq("abort_words", {16'd0, words_done}, 32'd2);
    check_eq("abort_error", {31'd0, error}, 32'd0);
    check_eq("abort_rd_cnt", rd_cnt, 32'd2);
    check_eq("abort_wr_cnt", wr_cnt, 32'd2);
    check_eq("abort_wr1_addr", wa(1), 32'hA04);
    check_eq("abort_wr1_data", wd(1), 32'h71);
    repeat (4) @(negedge clk);
    check_eq("abort_idle", {31'd0, busy}, 32'd0);
    check_eq("abort_no_more_req", rd_cnt + wr_cnt, 32'd4);

    // Fill request
    run_xfer(32'h400, 32'h300, 16'd4, 1'b1, 32'hDEAD_BEEF, 0, lat);
    check_eq("fill_wr_cnt", wr_cnt, 32'd4);
    check_eq("fill_words", {16'd0, words_done}, 32'd4);
`ifdef SCR1_DMA_FILL_EN
    check_eq("fill_rd_cnt", rd_cnt, 32'd0);
    check_eq("fill_latency", lat, 32'd9);
    for (int i = 0; i < 4; i++) begin
      check_eq("fill_wr_addr", wa(i), 32'h300 + 32'(4 * i));
      check_eq("fill_wr_data", wd(i), 32'hDEAD_BEEF);
    end
`else
    check_eq("fill_rd_cnt", rd_cnt, 32'd4);
    check_eq("fill_latency", lat, 32'd17);
    for (int i = 0; i < 4; i++) begin
      check_eq("fill_wr_addr", wa(i), 32'h300 + 32'(4 * i));
      check_eq("fill_wr_data", wd(i), 32'h40 + 32'(i));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
